hawk_ped_request: RTL and testbench

HAWK_PED_REQUEST -- requirements
Module: hawk_ped_request

---
 rtl/hawk_pkg.sv | 18 +
 rtl/hawk_debounce.sv | 41 ++++
 rtl/hawk_ped_request.sv | 157 +++++++++++++++
 tb/tb_hawk_ped_request.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_pkg.sv
// Shared definitions for the pedestrian request block: FSM encoding and
// default parameter values used by hawk_ped_request and hawk_debounce.
package hawk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SERVING = 2'd2,
        ST_LOCKOUT = 2'd3
    } req_state_t;

    localparam int DB_CYCLES_DEF     = 16;
    localparam int TICK_DIV_DEF      = 100;
    localparam int MIN_GAP_TICKS_DEF = 8;

    localparam logic [3:0] COUNT_MAX = 4'd15;

endpackage

// File: rtl/hawk_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for the
// pedestrian push button.
module hawk_debounce
    import hawk_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    // The count runs while the synchronized level disagrees with dout; the
    // commit happens on the sample after DB_CYCLES disagreements, which puts
    // the output change 2+DB_CYCLES edges after the first raw sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= 8'd0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(DB_CYCLES)) begin
                dout <= sync2;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/hawk_ped_request.sv
// Pedestrian request latch: debounced button, request FSM, tick divider and
// walk counter. Define HAWK_REQ_LOCKOUT_EN to add the post-crossing lockout.
module hawk_ped_request
    import hawk_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int MIN_GAP_TICKS = MIN_GAP_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ack,
    input  logic       cycle_done,
    input  logic       clr_count,
    input  logic       inc_count,
    output logic       YP,
    output logic [3:0] count,
    output logic       tick,
    output logic       btn_clean,
    output logic       req_pending,
    output logic       lockout
);

    localparam int DIV_W = $clog2(TICK_DIV);

    req_state_t       state;
    req_state_t       state_n;
    logic             pend;
    logic             pend_n;
    logic             clean_d;
    logic             press;
    logic [DIV_W-1:0] div;

    hawk_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (btn_raw),
        .dout (btn_clean)
    );

    assign press = btn_clean & ~clean_d;
    assign tick  = (div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_d <= 1'b0;
            div     <= '0;
        end else begin
            clean_d <= btn_clean;
            div     <= tick ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (clr_count) begin
            count <= 4'd0;
        end else if (inc_count && tick && count != COUNT_MAX) begin
            count <= count + 4'd1;
        end
    end

`ifdef HAWK_REQ_LOCKOUT_EN
    logic [7:0] gap;
    logic [7:0] gap_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= 8'd0;
        end else begin
            gap <= gap_n;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
`ifdef HAWK_REQ_LOCKOUT_EN
        gap_n   = gap;
`endif
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_n = ST_ARMED;
                end
            end
            // Presses while armed are dropped; ack takes priority.
            ST_ARMED: begin
                if (ack) begin
                    state_n = ST_SERVING;
                end
            end
            ST_SERVING: begin
                if (press) begin
                    pend_n = 1'b1;
                end
                if (cycle_done) begin
`ifdef HAWK_REQ_LOCKOUT_EN
                    state_n = ST_LOCKOUT;
                    gap_n   = 8'(MIN_GAP_TICKS);
`else
                    if (pend_n) begin
                        state_n = ST_ARMED;
                        pend_n  = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
`endif
                end
            end
            ST_LOCKOUT: begin
`ifdef HAWK_REQ_LOCKOUT_EN
                if (press) begin
                    pend_n = 1'b1;
                end
                if (gap == 8'd0) begin
                    if (pend_n) begin
                        state_n = ST_ARMED;
                        pend_n  = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (tick) begin
                    gap_n = gap - 8'd1;
                end
`else
                state_n = ST_IDLE;
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign YP          = (state == ST_ARMED);
    assign req_pending = pend | (state == ST_ARMED);
`ifdef HAWK_REQ_LOCKOUT_EN
    assign lockout     = (state == ST_LOCKOUT);
`else
    assign lockout     = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_ped_request.sv
// Directed bench for hawk_ped_request with DB_CYCLES=4, TICK_DIV=10,
// MIN_GAP_TICKS=2; expectations follow HAWK_REQ_LOCKOUT_EN when defined.
module tb_hawk_ped_request;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       ack = 1'b0;
    logic       cycle_done = 1'b0;
    logic       clr_count = 1'b0;
    logic       inc_count = 1'b0;
    logic       YP;
    logic [3:0] count;
    logic       tick;
    logic       btn_clean;
    logic       req_pending;
    logic       lockout;

    int n_checks = 0;
    int n_err    = 0;

    hawk_ped_request #(
        .DB_CYCLES    (4),
        .TICK_DIV     (10),
        .MIN_GAP_TICKS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .ack        (ack),
        .cycle_done (cycle_done),
        .clr_count  (clr_count),
        .inc_count  (inc_count),
        .YP         (YP),
        .count      (count),
        .tick       (tick),
        .btn_clean  (btn_clean),
        .req_pending(req_pending),
        .lockout    (lockout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_btn();
        btn_raw = 1'b1;
        step(10);
        btn_raw = 1'b0;
        step(10);
    endtask

    task automatic wait_lockout_end(output int n);
        n = 1;
        while (lockout && n < 40) begin
            step(1);
            if (lockout) n++;
        end
    endtask

    initial begin
        int   n;
        int   exp_cnt;
        logic t;
        logic seen_clean;
        logic seen_yp;

        step(3);
        check("reset_yp", YP, 0);
        check("reset_count", count, 0);
        check("reset_tick", tick, 0);
        check("reset_clean", btn_clean, 0);
        check("reset_pending", req_pending, 0);
        check("reset_lockout", lockout, 0);
        reset = 1'b0;

        // clean press: btn_clean at edge 6, YP at edge 7
        btn_raw = 1'b1;
        step(6);
        check("clean_e5", 32'(btn_clean), 0);
        step(1);
        check("clean_e6", btn_clean, 1);
        check("yp_e6", YP, 0);
        step(1);
        check("yp_e7", YP, 1);
        check("pend_armed", req_pending, 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("yp_after_ack", YP, 0);
        check("pend_serving", req_pending, 0);
        btn_raw = 1'b0;
        step(10);

        // press while serving is stored
        press_btn();
        check("pend_serving_press", req_pending, 1);
        check("yp_serving_press", YP, 0);
        cycle_done = 1'b1;
        step(1);
        cycle_done = 1'b0;
`ifdef HAWK_REQ_LOCKOUT_EN
        check("lockout_enter", lockout, 1);
        check("yp_in_lockout", YP, 0);
        wait_lockout_end(n);
        check("lockout_len_ok", 32'(n >= 11 && n <= 22), 1);
        check("lockout_exit", lockout, 0);
`else
        check("lockout_tied", lockout, 0);
`endif
        check("yp_rearm", YP, 1);
        check("pend_rearm", req_pending, 1);

        // press while armed is ignored
        press_btn();
        check("yp_armed_press", YP, 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("pend_ignored", req_pending, 0);
        cycle_done = 1'b1;
        step(1);
        cycle_done = 1'b0;
`ifdef HAWK_REQ_LOCKOUT_EN
        wait_lockout_end(n);
        check("lockout_exit2", lockout, 0);
`endif
        check("yp_idle", YP, 0);
        check("pend_idle", req_pending, 0);

        // ack/cycle_done in idle do nothing
        ack = 1'b1;
        cycle_done = 1'b1;
        step(1);
        ack = 1'b0;
        cycle_done = 1'b0;
        step(1);
        check("idle_ack_yp", YP, 0);
        check("idle_done_lockout", lockout, 0);

        // bounce every 2 cycles never debounces
        seen_clean = 1'b0;
        seen_yp    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            for (int j = 0; j < 2; j++) begin
                step(1);
                seen_clean |= btn_clean;
                seen_yp    |= YP;
            end
        end
        btn_raw = 1'b0;
        step(10);
        check("bounce_clean", seen_clean, 0);
        check("bounce_yp", seen_yp, 0);

        // tick period
        n = 0;
        while (!tick && n < 20) begin
            step(1);
            n++;
        end
        check("tick_found", tick, 1);
        step(1);
        n = 1;
        while (!tick && n < 20) begin
            step(1);
            n++;
        end
        check("tick_period", n, 10);

        // counter: clear, then saturating increment on ticks
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        check("count_clr", count, 0);
        inc_count = 1'b1;
        exp_cnt   = 0;
        for (int i = 0; i < 200; i++) begin
            t = tick;
            step(1);
            if (t && exp_cnt < 15) exp_cnt++;
            if (i % 25 == 24) check("count_step", count, exp_cnt);
        end
        check("count_sat", count, 15);
        n = 0;
        while (!tick && n < 20) begin
            step(1);
            n++;
        end
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        check("count_clr_wins", count, 0);
        step(25);
        inc_count = 1'b0;
        check("count_nonzero", 32'(count != 0), 1);

        // async reset while armed
        press_btn();
        check("yp_before_reset", YP, 1);
        btn_raw = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check("rst_yp", YP, 0);
        check("rst_pend", req_pending, 0);
        check("rst_count", count, 0);
        check("rst_tick", tick, 0);
        check("rst_clean", btn_clean, 0);
        check("rst_lockout", lockout, 0);
        btn_raw = 1'b0;
        step(3);
        reset = 1'b0;
        step(30);
        check("no_yp_after_reset", YP, 0);

        // button held through reset release needs full debounce
        btn_raw = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);
        check("held_clean_early", btn_clean, 0);
        check("held_yp_early", YP, 0);
        step(3);
        check("held_yp", YP, 1);
        btn_raw = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
